// File: rtl/key_hold_flash_if.sv
// Pushbutton-in / LED-bank-out bundle for the hold-time flasher.
// Latency: none (wires only).
// Backpressure: none; the key is free-running and the event report is a pulse.
interface key_hold_flash_if #(
  parameter int NUM_LEDS   = 4,
  parameter int NUM_LEVELS = 3
);
  localparam int LW = $clog2(NUM_LEVELS);

  logic                key;       // raw active-low pushbutton
  logic [NUM_LEDS-1:0] led_;      // active-low LED drive
  logic                busy;      // flash sequence running
  logic                ev_valid;  // one-cycle accepted-release pulse
  logic [LW-1:0]       ev_level;  // band of the last accepted release

  // Flasher side: takes the key, drives the LEDs and the report
  modport master (
    input  key,
    output led_, busy, ev_valid, ev_level
  );

  // Board side: drives the key, observes everything else
  modport slave (
    output key,
    input  led_, busy, ev_valid, ev_level
  );
endinterface

// File: rtl/key_hold_flash.sv
// Debounces an active-low key, bins its hold time into bands, flashes a per-band LED group.
// Latency: release is seen 2 sync + DEBOUNCE_CYCLES cycles after the pin; flashing starts 1 cycle later.
// Backpressure: none; a release while busy is dropped (or restarts the sequence when RESTART_ON_RELEASE=1).
module key_hold_flash #(
  parameter int                             NUM_LEDS           = 4,
  parameter int                             NUM_LEVELS         = 3,
  parameter int                             CNT_WIDTH          = 32,
  parameter int                             STEP_CYCLES        = 50_000_000,
  parameter int                             DEBOUNCE_CYCLES    = 1_000_000,
  parameter int                             HALF_PERIOD        = 12_500_000,
  parameter int                             BASE_FLASHES       = 5,
  parameter logic [NUM_LEVELS*NUM_LEDS-1:0] LEVEL_MASK         = {4'b1111, 4'b0001, 4'b0001},
  parameter bit                             RESTART_ON_RELEASE = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  key_hold_flash_if.master bus
);
  localparam int LW = $clog2(NUM_LEVELS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam int TW = $clog2(2 * (BASE_FLASHES << (NUM_LEVELS - 1)) + 1);
  localparam longint unsigned MAX_THR = longint'(NUM_LEVELS - 1) * longint'(STEP_CYCLES);

  // The largest band threshold must be representable by the hold counter
  if ((MAX_THR >> CNT_WIDTH) != 0) begin : g_thr_check
    $error("key_hold_flash: (NUM_LEVELS-1)*STEP_CYCLES does not fit in CNT_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_prev_q;
  logic [DW-1:0]        db_cnt_q;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  state_t               state_q, state_d;
  logic [HW-1:0]        hp_q, hp_d;
  logic [TW-1:0]        tog_q, tog_d;
  logic [LW-1:0]        lvl_q, lvl_d;
  logic                 ev_vld_q, ev_vld_d;
  logic [LW-1:0]        ev_lvl_q, ev_lvl_d;
  logic                 pend_q, pend_d;
  logic [LW-1:0]        pend_lvl_q, pend_lvl_d;

  logic                 press, release_ev;
  logic [LW-1:0]        lvl_cls;
  logic [TW-1:0]        tgt;
  logic [NUM_LEDS-1:0]  mask;

  assign press      = deb_prev_q & ~deb_q;
  assign release_ev = ~deb_prev_q & deb_q;
  assign mask       = LEVEL_MASK[lvl_q*NUM_LEDS +: NUM_LEDS];

  assign bus.led_     = (state_q == ON) ? ~mask : '1;
  assign bus.busy     = (state_q != IDLE);
  assign bus.ev_valid = ev_vld_q;
  assign bus.ev_level = ev_lvl_q;

  // Two-flop synchroniser; idles high so reset looks like a released key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.key;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      deb_prev_q <= deb_q;
      if (sync2_q != deb_q) begin
        if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q    <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Hold length: the press cycle counts as 1, saturating, cleared once released
  always_comb begin
    hold_d = '0;
    if (press)
      hold_d = CNT_WIDTH'(1);
    else if (!deb_q)
      hold_d = (hold_q == '1) ? hold_q : hold_q + CNT_WIDTH'(1);
  end

  // Band = number of thresholds k*STEP_CYCLES reached; the equality case goes up
  always_comb begin
    lvl_cls = '0;
    for (int k = 1; k < NUM_LEVELS; k++) begin
      if (hold_q >= CNT_WIDTH'(longint'(k) * longint'(STEP_CYCLES)))
        lvl_cls = LW'(k);
    end
  end

  // Flash sequencer; a release that lands on the completion cycle is parked one
  // cycle so the current sequence visibly ends before the new one starts
  always_comb begin
    logic          phase_end;
    logic          done;
    logic          start;
    logic [LW-1:0] start_lvl;

    state_d    = state_q;
    hp_d       = hp_q;
    tog_d      = tog_q;
    lvl_d      = lvl_q;
    ev_vld_d   = 1'b0;
    ev_lvl_d   = ev_lvl_q;
    pend_d     = pend_q;
    pend_lvl_d = pend_lvl_q;
    start      = 1'b0;
    start_lvl  = lvl_cls;

    tgt       = TW'(BASE_FLASHES) << lvl_q;
    tgt       = tgt << 1;
    phase_end = (hp_q == HW'(HALF_PERIOD - 1));
    done      = (state_q == OFF) && phase_end && ((tog_q + TW'(1)) == tgt);

    case (state_q)
      ON: begin
        if (phase_end) begin
          state_d = OFF;
          hp_d    = '0;
          tog_d   = tog_q + TW'(1);
        end else begin
          hp_d = hp_q + HW'(1);
        end
      end
      OFF: begin
        if (phase_end) begin
          state_d = done ? IDLE : ON;
          hp_d    = '0;
          tog_d   = done ? '0 : tog_q + TW'(1);
        end else begin
          hp_d = hp_q + HW'(1);
        end
      end
      default: ;
    endcase

    if (pend_q) begin
      start     = 1'b1;
      start_lvl = pend_lvl_q;
      pend_d    = 1'b0;
    end else if (release_ev) begin
      if (done) begin
        pend_d     = 1'b1;
        pend_lvl_d = lvl_cls;
      end else if ((state_q == IDLE) || RESTART_ON_RELEASE) begin
        start = 1'b1;
      end
    end

    if (start) begin
      state_d  = ON;
      hp_d     = '0;
      tog_d    = '0;
      lvl_d    = start_lvl;
      ev_vld_d = 1'b1;
      ev_lvl_d = start_lvl;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      state_q    <= IDLE;
      hp_q       <= '0;
      tog_q      <= '0;
      lvl_q      <= '0;
      ev_vld_q   <= 1'b0;
      ev_lvl_q   <= '0;
      pend_q     <= 1'b0;
      pend_lvl_q <= '0;
    end else begin
      hold_q     <= hold_d;
      state_q    <= state_d;
      hp_q       <= hp_d;
      tog_q      <= tog_d;
      lvl_q      <= lvl_d;
      ev_vld_q   <= ev_vld_d;
      ev_lvl_q   <= ev_lvl_d;
      pend_q     <= pend_d;
      pend_lvl_q <= pend_lvl_d;
    end
  end
endmodule
